// File: rtl/snn_img_loader.sv
// Image loader for the SNN core: packs a byte stream into a 784-pixel buffer,
// launches the core, serves pixel reads and hands back the classification.
module snn_img_loader #(
    parameter int unsigned NUM_PIXELS = 784,
    parameter int unsigned NUM_BYTES  = 98,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              start,
    input  logic [ADDR_W-1:0] addr_input_unit,
    output logic              q_input,
    input  logic              done,
    input  logic [3:0]        digit,
    output logic [3:0]        res_digit,
    output logic              res_err,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(NUM_BYTES);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_RUN,
        S_RESULT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_d;
    logic [NUM_PIXELS-1:0] img_buf;
    logic               wr_en;
    logic               rx_ready_d, start_d, busy_d, res_valid_d, res_err_d;
    logic [3:0]         res_digit_d;

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt;
        res_digit_d = res_digit;
        res_err_d   = res_err;
        wr_en       = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (rx_valid && rx_ready) begin
                    wr_en = 1'b1;
                    if (byte_cnt == CNT_W'(NUM_BYTES - 1)) begin
                        state_d    = S_START;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt + CNT_W'(1);
                    end
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (done) begin
                    res_digit_d = digit;
                    res_err_d   = (digit > 4'd9);
                    state_d     = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_valid && res_ready) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase

        // abort overrides everything, including a byte accepted this cycle
        if (abort) begin
            state_d    = S_LOAD;
            byte_cnt_d = '0;
            wr_en      = 1'b0;
        end

        rx_ready_d  = (state_d == S_LOAD);
        start_d     = (state_d == S_START);
        busy_d      = (state_d == S_START) || (state_d == S_RUN);
        res_valid_d = (state_d == S_RESULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            byte_cnt  <= '0;
            rx_ready  <= 1'b0;
            start     <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_digit <= 4'd0;
            res_err   <= 1'b0;
            q_input   <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_cnt  <= byte_cnt_d;
            rx_ready  <= rx_ready_d;
            start     <= start_d;
            busy      <= busy_d;
            res_valid <= res_valid_d;
            res_digit <= res_digit_d;
            res_err   <= res_err_d;
            if (addr_input_unit < ADDR_W'(NUM_PIXELS)) q_input <= img_buf[addr_input_unit];
            else                                       q_input <= 1'b0;
        end
    end

    // Image buffer is intentionally not reset; byte k lands on pixels 8k..8k+7
    always_ff @(posedge clk) begin
        if (wr_en) img_buf[{byte_cnt, 3'b000} +: 8] <= rx_data;
    end

endmodule

// File: tb/tb_snn_img_loader.sv
// Self-checking bench for snn_img_loader: vector tables, handshake sequences
// and randomized images checked against a pixel-array model.
module tb_snn_img_loader;

    localparam int unsigned NP = 784;
    localparam int unsigned NB = 98;
    localparam int unsigned AW = 10;

    logic          clk, rst_n, abort;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_ready, start;
    logic [AW-1:0] addr_input_unit;
    logic          q_input, done;
    logic [3:0]    digit, res_digit;
    logic          res_err, res_valid, res_ready, busy;

    snn_img_loader #(.NUM_PIXELS(NP), .NUM_BYTES(NB), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .start(start), .addr_input_unit(addr_input_unit), .q_input(q_input),
        .done(done), .digit(digit), .res_digit(res_digit), .res_err(res_err),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic       model [NP];
    logic [7:0] tx [NB];

    typedef struct {
        logic [AW-1:0] addr;
        logic          q;
    } vec_t;
    vec_t vt [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_q(input int a);
        if (a < int'(NP)) return model[a];
        return 1'b0;
    endfunction

    task automatic load_model();
        for (int k = 0; k < int'(NB); k++)
            for (int i = 0; i < 8; i++)
                model[8*k+i] = tx[k][i];
    endtask

    // Offer tx[0..n-1] with random gaps; a byte counts only when rx_ready was high
    task automatic send_bytes(input int n, input int gap_pct);
        int acc = 0;
        int guard = 0;
        logic v;
        logic early = 1'b0;
        while (acc < n && guard < 4000) begin
            v = (gap_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= gap_pct);
            rx_valid = v;
            rx_data  = v ? tx[acc] : 8'($urandom);
            if (v && rx_ready) acc++;
            @(negedge clk);
            if (start && acc < int'(NB)) early = 1'b1;
            guard++;
        end
        rx_valid = 1'b0;
        check("load_timeout", 32'(guard < 4000), 32'd1);
        check("early_start", 32'(early), 32'd0);
    endtask

    task automatic full_image(input int gap_pct);
        send_bytes(int'(NB), gap_pct);
        load_model();
        check("start_pulse", 32'(start), 32'd1);
        check("rx_ready_start", 32'(rx_ready), 32'd0);
        check("busy_start", 32'(busy), 32'd1);
    endtask

    task automatic read_px(input int a);
        addr_input_unit = AW'(a);
        @(negedge clk);
        check("q_input", 32'(q_input), 32'(model_q(a)));
    endtask

    task automatic do_result(input logic [3:0] d);
        logic exp_err;
        exp_err = (int'(d) > 9);
        done = 1'b1;
        digit = d;
        @(negedge clk);
        done = 1'b0;
        digit = 4'($urandom);
        repeat (5) begin
            check("res_valid_hold", 32'(res_valid), 32'd1);
            check("res_digit", 32'(res_digit), 32'(d));
            check("res_err", 32'(res_err), 32'(exp_err));
            check("rx_ready_result", 32'(rx_ready), 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", 32'(res_valid), 32'd0);
        check("rx_ready_back", 32'(rx_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0] = '{addr: 10'd0,   q: 1'b1};
        vt[1] = '{addr: 10'd1,   q: 1'b0};
        vt[2] = '{addr: 10'd783, q: 1'b0};
        vt[3] = '{addr: 10'd800, q: 1'b0};

        rst_n = 1'b0; abort = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
        addr_input_unit = '0; done = 1'b0; digit = 4'd0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_q_input", 32'(q_input), 32'd0);
        check("rst_res_digit", 32'(res_digit), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rx_ready_after_rst", 32'(rx_ready), 32'd1);

        // Image 1: single set pixel, back-to-back bytes, table-driven reads
        for (int k = 0; k < int'(NB); k++) tx[k] = 8'h00;
        tx[0] = 8'h01;
        full_image(0);
        @(negedge clk);
        check("start_one_cycle", 32'(start), 32'd0);
        check("busy_run", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            addr_input_unit = vt[i].addr;
            @(negedge clk);
            check("q_table", 32'(q_input), 32'(vt[i].q));
        end
        do_result(4'd7);

        // done while loading must not produce a result
        done = 1'b1; digit = 4'd5;
        @(negedge clk);
        done = 1'b0;
        repeat (3) begin
            check("done_in_load", 32'(res_valid), 32'd0);
            @(negedge clk);
        end

        // Image 2: alternating AA/55 with gaps; done during START is ignored
        for (int k = 0; k < int'(NB); k++) tx[k] = k[0] ? 8'h55 : 8'hAA;
        full_image(40);
        done = 1'b1; digit = 4'd3;
        @(negedge clk);
        done = 1'b0;
        check("start_done_ignored", 32'(res_valid), 32'd0);
        check("busy_run2", 32'(busy), 32'd1);
        rx_valid = 1'b1; rx_data = 8'hFF;
        for (int a = 0; a < int'(NP); a++) read_px(a);
        repeat (20) read_px(int'($urandom_range(1023)));
        rx_valid = 1'b0;
        check("rx_ignored_run", 32'(rx_ready), 32'd0);
        do_result(4'd12);

        // Abort after 50 bytes, then a fresh random image
        for (int k = 0; k < int'(NB); k++) tx[k] = 8'($urandom);
        send_bytes(50, 30);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_rx_ready", 32'(rx_ready), 32'd1);
        check("abort_start", 32'(start), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int k = 0; k < int'(NB); k++) tx[k] = 8'($urandom);
        full_image(20);
        @(negedge clk);
        repeat (40) read_px(int'($urandom_range(NP - 1)));

        // Asynchronous reset in RUN clears outputs without waiting for a clock
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rx_ready", 32'(rx_ready), 32'd0);
        check("arst_res_digit", 32'(res_digit), 32'd0);
        check("arst_res_err", 32'(res_err), 32'd0);
        check("arst_q_input", 32'(q_input), 32'd0);
        check("arst_start", 32'(start), 32'd0);
        check("arst_res_valid", 32'(res_valid), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_arst_load", 32'(rx_ready), 32'd1);
        check("post_arst_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
